// File: rtl/mem_writer.sv
// mem_writer: receives pixel words from the HPS over a four-phase val/ack
// handshake and writes them in order into NUM_MEMS banks of WORDS_PER_MEM
// M10k words, raising done when the whole frame has been written.
// Optional running checksum of written words: define MEM_WRITER_CHECKSUM_EN.
module mem_writer #(
  parameter int DATA_W        = 20,
  parameter int WORDS_PER_MEM = 480,
  parameter int NUM_MEMS      = 240,
  parameter int ADDR_W        = 10,
  parameter int SEL_W         = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_val,
  input  logic [31:0]       arm_data,
  output logic              fpga_ack,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  which_mem,
  output logic              mem_we,
  output logic              done,
  output logic [31:0]       checksum,
  output logic [31:0]       count
);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_WRITE = 3'd1,
    S_HOLD  = 3'd2,
    S_ADV   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS_PER_MEM - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_MEMS - 1);

  state_t state;
  state_t state_nxt;

  // Bits above DATA_W of the HPS word carry nothing for this memory.
  logic unused_arm_hi;
  assign unused_arm_hi = ^arm_data[31:DATA_W];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  // Next-state logic for the handshake sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (arm_val) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_HOLD;
      S_HOLD:  if (!arm_val) state_nxt = S_ADV;
      S_ADV: begin
        if (addr == ADDR_LAST && which_mem == SEL_LAST) state_nxt = S_DONE;
        else                                            state_nxt = S_WAIT;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_WAIT;
    endcase
  end

  // Control outputs decoded from the registered state, so they are glitch-free
  // and match the one-cycle write strobe / held acknowledge timing exactly.
  always_comb begin
    mem_we   = 1'b0;
    fpga_ack = 1'b0;
    done     = 1'b0;
    case (state)
      S_WRITE: mem_we   = 1'b1;
      S_HOLD:  fpga_ack = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  assign count = 32'(state);

  // Capture write data and walk the bank/word address with explicit wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wr_data <= '0;
      addr        <= '0;
      which_mem   <= '0;
    end else begin
      if (state == S_WAIT && arm_val) mem_wr_data <= arm_data[DATA_W-1:0];
      if (state == S_ADV) begin
        if (addr != ADDR_LAST) begin
          addr <= addr + 1'b1;
        end else begin
          addr <= '0;
          if (which_mem == SEL_LAST) which_mem <= '0;
          else                       which_mem <= which_mem + 1'b1;
        end
      end
    end
  end

`ifdef MEM_WRITER_CHECKSUM_EN
  // Running sum of every word actually written; holds once the frame is done.
  always_ff @(posedge clk) begin
    if (reset)                checksum <= '0;
    else if (state == S_WRITE) checksum <= checksum + 32'(mem_wr_data);
  end
`else
  assign checksum = '0;
`endif

endmodule
